// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the single-bus datapath.
// The sequencer side (master) consumes IR/Stop and drives every control line.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Stop;
  logic        Run;
  logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, BAout, Cout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutportIn, Rin;
  logic        Gra, Grb, Grc, Rout;
  logic        Read, Write;
  logic [4:0]  ALU_Control;
  logic        Illegal;

  modport master (
    input  IR, Stop,
    output Run,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, BAout, Cout,
    output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutportIn, Rin,
    output Gra, Grb, Grc, Rout, Read, Write, ALU_Control, Illegal
  );

  modport slave (
    output IR, Stop,
    input  Run,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, BAout, Cout,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutportIn, Rin,
    input  Gra, Grb, Grc, Rout, Read, Write, ALU_Control, Illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: fetch in T0-T2,
// decode IR[31:27], run T3..T7 per opcode, then return to T0 (or PAUSE/HALT).
module control_sequencer #(
  parameter logic [4:0] INC_OP = 5'd12,
  parameter logic [4:0] ADD_OP = 5'd3
) (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9,
    S_PAUSE = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [4:0] opcode;

  // Opcode classes; each maps to one execute step list.
  logic is_ld, is_ldi, is_st, is_rtype, is_imm, is_muldiv, is_negnot;
  logic is_jr, is_in, is_out, is_mfhi, is_mflo, is_nop, is_halt;
  logic has_exec, is_undef;
  state_t last_exec;

  assign opcode    = bus.IR[31:27];
  assign is_ld     = (opcode == 5'd0);
  assign is_ldi    = (opcode == 5'd1);
  assign is_st     = (opcode == 5'd2);
  assign is_rtype  = (opcode >= 5'd3)  && (opcode <= 5'd11);
  assign is_imm    = (opcode >= 5'd12) && (opcode <= 5'd14);
  assign is_muldiv = (opcode == 5'd15) || (opcode == 5'd16);
  assign is_negnot = (opcode == 5'd17) || (opcode == 5'd18);
  assign is_jr     = (opcode == 5'd20);
  assign is_in     = (opcode == 5'd22);
  assign is_out    = (opcode == 5'd23);
  assign is_mfhi   = (opcode == 5'd24);
  assign is_mflo   = (opcode == 5'd25);
  assign is_nop    = (opcode == 5'd26);
  assign is_halt   = (opcode == 5'd27);
  assign has_exec  = is_ld | is_ldi | is_st | is_rtype | is_imm | is_muldiv | is_negnot |
                     is_jr | is_in | is_out | is_mfhi | is_mflo;
  assign is_undef  = ~has_exec & ~is_nop & ~is_halt;

  // Final execute state of the decoded instruction; the edge after it is the boundary.
  always_comb begin
    last_exec = S_T3;
    if (is_ld || is_st)                       last_exec = S_T7;
    else if (is_muldiv)                       last_exec = S_T6;
    else if (is_rtype || is_imm || is_ldi)    last_exec = S_T5;
    else if (is_negnot)                       last_exec = S_T4;
  end

  // State and sticky illegal-opcode flag; clr aborts at once, so no step completes after it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state: every route into T0 is an instruction boundary where Stop diverts to PAUSE.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RESET: state_d = bus.Stop ? S_PAUSE : S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        if (is_halt)       state_d = S_HALT;
        else if (has_exec) state_d = S_T3;
        else begin
          state_d = bus.Stop ? S_PAUSE : S_T0;
          if (is_undef) illegal_d = 1'b1;
        end
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == last_exec) state_d = bus.Stop ? S_PAUSE : S_T0;
        else                      state_d = state_t'(state_q + 4'd1);
      end
      S_HALT:  state_d = S_HALT;
      S_PAUSE: state_d = bus.Stop ? S_PAUSE : S_T0;
      default: state_d = S_RESET;
    endcase
  end

  // Moore control outputs from the registered state and the held opcode.
  always_comb begin
    bus.Run = 1'b0;
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.MDRout = 1'b0;
    bus.HIout = 1'b0; bus.LOout = 1'b0; bus.InPortout = 1'b0; bus.BAout = 1'b0;
    bus.Cout = 1'b0;
    bus.PCin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
    bus.Zin = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0; bus.OutportIn = 1'b0; bus.Rin = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rout = 1'b0;
    bus.Read = 1'b0; bus.Write = 1'b0;
    bus.ALU_Control = 5'd0;
    case (state_q)
      S_T0: begin
        bus.Run = 1'b1;
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.ALU_Control = INC_OP; bus.Zin = 1'b1;
      end
      S_T1: begin
        bus.Run = 1'b1;
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.Run = 1'b1;
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        bus.Run = 1'b1;
        if (is_rtype || is_imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else if (is_muldiv) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_negnot) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.ALU_Control = opcode; bus.Zin = 1'b1;
        end else if (is_jr) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
        end else if (is_in) begin
          bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_out) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutportIn = 1'b1;
        end else if (is_mfhi) begin
          bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else if (is_mflo) begin
          bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T4: begin
        bus.Run = 1'b1;
        if (is_rtype) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ALU_Control = opcode; bus.Zin = 1'b1;
        end else if (is_imm) begin
          bus.Cout = 1'b1; bus.ALU_Control = opcode; bus.Zin = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          bus.Cout = 1'b1; bus.ALU_Control = ADD_OP; bus.Zin = 1'b1;
        end else if (is_muldiv) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.ALU_Control = opcode; bus.Zin = 1'b1;
        end else if (is_negnot) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T5: begin
        bus.Run = 1'b1;
        bus.Zlowout = 1'b1;
        if (is_ld || is_st) bus.MARin = 1'b1;
        else if (is_muldiv) bus.LOin = 1'b1;
        else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T6: begin
        bus.Run = 1'b1;
        if (is_ld) begin
          bus.Read = 1'b1; bus.MDRin = 1'b1;
        end else if (is_st) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
        end else begin
          bus.Zhighout = 1'b1; bus.HIin = 1'b1;
        end
      end
      S_T7: begin
        bus.Run = 1'b1;
        if (is_ld) begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else begin
          bus.Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.Illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-by-cycle scoreboard bench for control_sequencer: expected control
// words are queued per instruction and compared once per clock.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed control word: bit positions of each control line.
  localparam logic [31:0] M_PCOUT     = 32'h1 << 0;
  localparam logic [31:0] M_ZLOWOUT   = 32'h1 << 1;
  localparam logic [31:0] M_ZHIGHOUT  = 32'h1 << 2;
  localparam logic [31:0] M_MDROUT    = 32'h1 << 3;
  localparam logic [31:0] M_HIOUT     = 32'h1 << 4;
  localparam logic [31:0] M_LOOUT     = 32'h1 << 5;
  localparam logic [31:0] M_INPORTOUT = 32'h1 << 6;
  localparam logic [31:0] M_BAOUT     = 32'h1 << 7;
  localparam logic [31:0] M_COUT      = 32'h1 << 8;
  localparam logic [31:0] M_PCIN      = 32'h1 << 9;
  localparam logic [31:0] M_MARIN     = 32'h1 << 10;
  localparam logic [31:0] M_MDRIN     = 32'h1 << 11;
  localparam logic [31:0] M_IRIN      = 32'h1 << 12;
  localparam logic [31:0] M_YIN       = 32'h1 << 13;
  localparam logic [31:0] M_ZIN       = 32'h1 << 14;
  localparam logic [31:0] M_HIIN      = 32'h1 << 15;
  localparam logic [31:0] M_LOIN      = 32'h1 << 16;
  localparam logic [31:0] M_OUTPORTIN = 32'h1 << 17;
  localparam logic [31:0] M_RIN       = 32'h1 << 18;
  localparam logic [31:0] M_GRA       = 32'h1 << 19;
  localparam logic [31:0] M_GRB       = 32'h1 << 20;
  localparam logic [31:0] M_GRC       = 32'h1 << 21;
  localparam logic [31:0] M_ROUT      = 32'h1 << 22;
  localparam logic [31:0] M_READ      = 32'h1 << 23;
  localparam logic [31:0] M_WRITE     = 32'h1 << 24;

  int checks   = 0;
  int failures = 0;
  logic ill_exp = 1'b0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [31:0] observed();
    return {bus.Illegal, bus.Run, bus.ALU_Control, bus.Write, bus.Read, bus.Rout,
            bus.Grc, bus.Grb, bus.Gra, bus.Rin, bus.OutportIn, bus.LOin, bus.HIin,
            bus.Zin, bus.Yin, bus.IRin, bus.MDRin, bus.MARin, bus.PCin, bus.Cout,
            bus.BAout, bus.InPortout, bus.LOout, bus.HIout, bus.MDRout, bus.Zhighout,
            bus.Zlowout, bus.PCout};
  endfunction

  // Active sequencing word: Run=1, given lines and ALU code.
  function automatic logic [31:0] w(input logic [31:0] m, input logic [4:0] alu);
    return m | ({27'b0, alu} << 25) | 32'h4000_0000 | (ill_exp ? 32'h8000_0000 : 32'h0);
  endfunction

  // Idle word (RESET/PAUSE/HALT): everything 0 except the sticky flag.
  function automatic logic [31:0] z();
    return ill_exp ? 32'h8000_0000 : 32'h0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] word);
    exp_q.push_back(word);
    tag_q.push_back(tag);
  endtask

  // Queue the full expected control sequence for one opcode.
  task automatic push_instr(input logic [4:0] op);
    string t;
    t = $sformatf("op%0d", op);
    push({t, "_T0"}, w(M_PCOUT | M_MARIN | M_ZIN, 5'd12));
    push({t, "_T1"}, w(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0));
    push({t, "_T2"}, w(M_MDROUT | M_IRIN, 5'd0));
    if (op >= 5'd3 && op <= 5'd11) begin
      push({t, "_T3"}, w(M_GRB | M_ROUT | M_YIN, 5'd0));
      push({t, "_T4"}, w(M_GRC | M_ROUT | M_ZIN, op));
      push({t, "_T5"}, w(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push({t, "_T3"}, w(M_GRB | M_ROUT | M_YIN, 5'd0));
      push({t, "_T4"}, w(M_COUT | M_ZIN, op));
      push({t, "_T5"}, w(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
    end else if (op <= 5'd2) begin
      push({t, "_T3"}, w(M_GRB | M_BAOUT | M_YIN, 5'd0));
      push({t, "_T4"}, w(M_COUT | M_ZIN, 5'd3));
      if (op == 5'd1) begin
        push({t, "_T5"}, w(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
      end else begin
        push({t, "_T5"}, w(M_ZLOWOUT | M_MARIN, 5'd0));
        if (op == 5'd0) begin
          push({t, "_T6"}, w(M_READ | M_MDRIN, 5'd0));
          push({t, "_T7"}, w(M_MDROUT | M_GRA | M_RIN, 5'd0));
        end else begin
          push({t, "_T6"}, w(M_GRA | M_ROUT | M_MDRIN, 5'd0));
          push({t, "_T7"}, w(M_WRITE, 5'd0));
        end
      end
    end else if (op == 5'd15 || op == 5'd16) begin
      push({t, "_T3"}, w(M_GRA | M_ROUT | M_YIN, 5'd0));
      push({t, "_T4"}, w(M_GRB | M_ROUT | M_ZIN, op));
      push({t, "_T5"}, w(M_ZLOWOUT | M_LOIN, 5'd0));
      push({t, "_T6"}, w(M_ZHIGHOUT | M_HIIN, 5'd0));
    end else if (op == 5'd17 || op == 5'd18) begin
      push({t, "_T3"}, w(M_GRB | M_ROUT | M_ZIN, op));
      push({t, "_T4"}, w(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
    end else if (op == 5'd20) push({t, "_T3"}, w(M_GRA | M_ROUT | M_PCIN, 5'd0));
    else if (op == 5'd22) push({t, "_T3"}, w(M_INPORTOUT | M_GRA | M_RIN, 5'd0));
    else if (op == 5'd23) push({t, "_T3"}, w(M_GRA | M_ROUT | M_OUTPORTIN, 5'd0));
    else if (op == 5'd24) push({t, "_T3"}, w(M_HIOUT | M_GRA | M_RIN, 5'd0));
    else if (op == 5'd25) push({t, "_T3"}, w(M_LOOUT | M_GRA | M_RIN, 5'd0));
    else if (op == 5'd27) begin
      for (int i = 0; i < 10; i++) push($sformatf("%s_halt%0d", t, i), z());
    end else if (op != 5'd26) begin
      ill_exp = 1'b1;
    end
  endtask

  // Pop and compare one expected word per clock. IR is loaded during T0
  // (after the first comparison); Stop takes act_val after entry act_idx.
  task automatic drain(input logic set_ir, input logic [31:0] ir,
                       input int act_idx, input logic act_val);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      #1;
      check_eq(tag_q.pop_front(), observed(), exp_q.pop_front());
      if (k == 0 && set_ir) bus.IR = ir;
      if (k == act_idx) bus.Stop = act_val;
      k++;
    end
  endtask

  task automatic run_instr(input logic [4:0] op, input int keep);
    push_instr(op);
    while (keep > 0 && exp_q.size() > keep) begin
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
    end
    drain(1'b1, {op, 27'h0}, -1, 1'b0);
  endtask

  // Release clr just after a rising edge so one full RESET cycle is visible.
  task automatic release_reset();
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    #1 check_eq("reset_hold", observed(), 32'h0);
  endtask

  logic [4:0] prog[] = '{5'd24, 5'd3, 5'd0, 5'd2, 5'd1, 5'd13, 5'd15, 5'd18, 5'd23, 5'd20, 5'd26};

  initial begin
    clr = 1'b1;
    bus.Stop = 1'b0;
    bus.IR = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 check_eq("reset", observed(), 32'h0);
    end
    release_reset();

    foreach (prog[i]) run_instr(prog[i], 0);

    // Stop raised during add T4: instruction completes, then PAUSE until Stop drops.
    push_instr(5'd3);
    drain(1'b1, 32'h18800000, 4, 1'b1);
    for (int i = 0; i < 3; i++) push($sformatf("pause%0d", i), z());
    drain(1'b0, 32'h0, 2, 1'b0);
    run_instr(5'd25, 0);

    // Undefined opcode: behaves as nop, Illegal sticks.
    run_instr(5'd19, 0);
    run_instr(5'd26, 0);

    // clr during st T6: immediate abort, Write never asserted, Illegal cleared.
    run_instr(5'd2, 7);
    clr = 1'b1;
    ill_exp = 1'b0;
    #1 check_eq("clr_abort", observed(), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_eq($sformatf("clr_hold%0d", i), observed(), 32'h0);
    end
    release_reset();
    run_instr(5'd2, 0);

    // Halt: outputs stay 0, Run=0.
    run_instr(5'd27, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
